tdc_readout_arb: RTL and testbench

TDC_READOUT_ARB -- requirements
Module: tdc_readout_arb

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_readout_arb_rr_pick.sv | 25 ++
 rtl/tdc_readout_arb.sv | 145 ++++++++++++++
 tb/tb_tdc_readout_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and the FIFO entry layout for the TDC readout arbiter.
package tdc_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_TS     = 2'd2;
  localparam logic [1:0] ADR_TAG    = 2'd3;

  localparam int FLUSH_BIT = 31;
  localparam int CHAN_W    = 3;
  localparam int TS_MAX_W  = 32;

  // Timestamps are stored zero-extended so the entry layout is width independent.
  typedef struct packed {
    logic [CHAN_W-1:0]   chan;
    logic [TS_MAX_W-1:0] ts;
  } entry_t;

endpackage

// File: rtl/tdc_readout_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, modulo N.
module rr_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic         gnt_valid
);

  // Scan distances from ptr outward; the first hit wins and masks later ones.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!gnt_valid && req[k] && (((int'(ptr) + off) % N) == k)) begin
          gnt[k]    = 1'b1;
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tdc_readout_arb.sv
// Round-robin readout of NCHAN TDC channels into an event FIFO, drained over
// a Wishbone classic slave (CTRL / STATUS / TS / TAG).
module tdc_readout_arb
  import tdc_pkg::*;
#(
  parameter int NCHAN = 5,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NCHAN-1:0]      ch_valid_i,
  input  logic [NCHAN*TS_W-1:0] ch_ts_i,
  output logic [NCHAN-1:0]      ch_ack_o,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [1:0]            wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [NCHAN-1:0] en;
  logic             ovf;
  logic [2:0]       rr_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];
  logic             abort_q;
  logic             tag_pop_q;

  logic                access;
  logic                wr_ctrl;
  logic                flush_req;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [NCHAN-1:0]    pending;
  logic [NCHAN-1:0]    gnt;
  logic                gnt_valid;
  logic [2:0]          gnt_idx;
  logic [TS_MAX_W-1:0] gnt_ts;
  logic [31:0]         rd_data;
  entry_t              head;
  logic                unused_dat;

  // abort_q blocks the ack of a cycle that was already in flight during reset.
  assign access    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~abort_q;
  assign wr_ctrl   = access & wbs_we_i & (wbs_adr_i == ADR_CTRL);
  assign flush_req = wr_ctrl & wbs_dat_i[FLUSH_BIT];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign pending   = ch_valid_i & en;
  assign head      = mem[rd_ptr];
  assign unused_dat = &{1'b0, wbs_dat_i[FLUSH_BIT-1:NCHAN]};

  rr_pick #(.N(NCHAN)) u_rr_pick (
    .req       (pending),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Fullness uses the registered count, so a pop never makes room in its own cycle.
  assign push     = gnt_valid & ~full & ~flush_req & ~wb_rst_i;
  assign pop      = tag_pop_q & ~flush_req & ~wb_rst_i;
  assign ch_ack_o = push ? gnt : '0;

  always_comb begin
    gnt_idx = '0;
    gnt_ts  = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (gnt[k]) begin
        gnt_idx            = 3'(k);
        gnt_ts[TS_W-1:0]   = ch_ts_i[k*TS_W +: TS_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i)
      ADR_CTRL:   rd_data[NCHAN-1:0] = en;
      ADR_STATUS: begin
        rd_data[31]          = ovf;
        rd_data[21:16]       = 6'(count);
        rd_data[NCHAN-1:0]   = pending;
      end
      ADR_TS:     if (!empty) rd_data = head.ts;
      ADR_TAG:    if (!empty) begin
        rd_data[31]  = 1'b1;
        rd_data[2:0] = head.chan;
      end
      default:    rd_data = '0;
    endcase
  end

  // Read data is captured with the ack; a TAG read pops during its ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= '0;
      tag_pop_q <= 1'b0;
      abort_q   <= wbs_stb_i & wbs_cyc_i;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access & ~wbs_we_i) ? rd_data : '0;
      tag_pop_q <= access & ~wbs_we_i & (wbs_adr_i == ADR_TAG) & ~empty;
      if (!(wbs_stb_i & wbs_cyc_i)) abort_q <= 1'b0;
      if (wr_ctrl) en <= wbs_dat_i[NCHAN-1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == 3'(NCHAN-1)) ? 3'd0 : gnt_idx + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (full && (|pending)) ovf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {gnt_idx, gnt_ts};
  end

endmodule

// File: tb/tb_tdc_readout_arb.sv
// Directed bench for tdc_readout_arb with a scoreboard of granted events.
module tb_tdc_readout_arb;
  import tdc_pkg::*;

  localparam int NCHAN = 5;
  localparam int TS_W  = 32;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCHAN-1:0]      ch_valid;
  logic [NCHAN*TS_W-1:0] ch_ts;
  logic [NCHAN-1:0]      ch_ack;
  logic                  wbs_stb;
  logic                  wbs_cyc;
  logic                  wbs_we;
  logic [1:0]            wbs_adr;
  logic [31:0]           wbs_dat_w;
  logic [31:0]           wbs_dat_r;
  logic                  wbs_ack;

  int          tests_run = 0;
  int          tests_failed = 0;
  entry_t      sb[$];
  logic [31:0] rdat;

  tdc_readout_arb #(.NCHAN(NCHAN), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .ch_valid_i (ch_valid),
    .ch_ts_i    (ch_ts),
    .ch_ack_o   (ch_ack),
    .wbs_stb_i  (wbs_stb),
    .wbs_cyc_i  (wbs_cyc),
    .wbs_we_i   (wbs_we),
    .wbs_adr_i  (wbs_adr),
    .wbs_dat_i  (wbs_dat_w),
    .wbs_dat_o  (wbs_dat_r),
    .wbs_ack_o  (wbs_ack)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] data);
    next_cycle();
    wbs_stb = 1'b1; wbs_cyc = 1'b1; wbs_we = 1'b0; wbs_adr = adr;
    next_cycle();
    #1;
    check("wb_read_ack", 32'(wbs_ack), 32'd1);
    data = wbs_dat_r;
    wbs_stb = 1'b0; wbs_cyc = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] data);
    next_cycle();
    wbs_stb = 1'b1; wbs_cyc = 1'b1; wbs_we = 1'b1; wbs_adr = adr; wbs_dat_w = data;
    next_cycle();
    #1;
    check("wb_write_ack", 32'(wbs_ack), 32'd1);
    wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic expect_ack(input logic [NCHAN-1:0] exp, input string tag);
    entry_t e;
    check(tag, 32'(ch_ack), 32'(exp));
    for (int k = 0; k < NCHAN; k++) begin
      if (exp[k]) begin
        e.chan = 3'(k);
        e.ts   = 32'(ch_ts[k*TS_W +: TS_W]);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_status(input logic ovf_e, input logic [NCHAN-1:0] pend_e);
    logic [31:0] exp;
    exp = '0;
    exp[31] = ovf_e;
    exp[21:16] = 6'(sb.size());
    exp[NCHAN-1:0] = pend_e;
    wb_read(ADR_STATUS, rdat);
    check("status", rdat, exp);
  endtask

  task automatic check_ts();
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb[0].ts : 32'd0;
    wb_read(ADR_TS, rdat);
    check("ts", rdat, exp);
  endtask

  task automatic check_tag();
    entry_t      e;
    logic [31:0] exp;
    exp = '0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      exp = {1'b1, 28'd0, e.chan};
    end
    wb_read(ADR_TAG, rdat);
    check("tag", rdat, exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0; wbs_adr = '0; wbs_dat_w = '0;
    ch_valid = '0;
    ch_ts = '0;
    for (int k = 0; k < NCHAN; k++) ch_ts[k*TS_W +: TS_W] = 32'h100 + 32'(k);

    // Reset values
    repeat (2) next_cycle();
    #1;
    check("rst_wbs_ack", 32'(wbs_ack), 32'd0);
    check("rst_wbs_dat", wbs_dat_r, 32'd0);
    check("rst_ch_ack", 32'(ch_ack), 32'd0);
    rst = 1'b0;
    wb_read(ADR_CTRL, rdat);
    check("ctrl_after_rst", rdat, 32'd0);
    check_status(1'b0, '0);

    // Single event on channel 2, then peek and pop it
    wb_write(ADR_CTRL, 32'h0000_001F);
    next_cycle();
    ch_ts[2*TS_W +: TS_W] = 32'h1234;
    ch_valid = 5'b00100;
    #1;
    expect_ack(5'b00100, "ack_ch2");
    next_cycle();
    ch_valid = '0;
    #1;
    expect_ack('0, "ack_ch2_single_pulse");
    check_status(1'b0, '0);
    check_ts();
    check_tag();
    check_status(1'b0, '0);
    check_tag();
    check_ts();

    // Round-robin order with every channel requesting, rr_ptr cleared by FLUSH
    wb_write(ADR_CTRL, 32'h8000_001F);
    wb_read(ADR_CTRL, rdat);
    check("ctrl_flush_reads0", rdat, 32'h0000_001F);
    for (int k = 0; k < NCHAN; k++) ch_ts[k*TS_W +: TS_W] = 32'h100 + 32'(k);
    next_cycle();
    ch_valid = '1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      #1;
      expect_ack(5'(1 << (i % NCHAN)), "rr_order");
    end
    next_cycle();
    ch_valid = '0;
    wb_write(ADR_STATUS, 32'hFFFF_FFFF);
    wb_write(ADR_TAG, 32'h0000_0000);
    check_status(1'b0, '0);
    check_ts();
    repeat (6) check_tag();
    check_status(1'b0, '0);

    // Fill to DEPTH, ninth request blocked and overflow flagged
    for (int i = 0; i < DEPTH; i++) begin
      next_cycle();
      ch_valid = 5'(1 << (i % NCHAN));
      #1;
      expect_ack(ch_valid, "fill");
    end
    next_cycle();
    ch_valid = 5'b01000;
    #1;
    expect_ack('0, "full_no_grant");
    check_status(1'b1, 5'b01000);
    check_tag();
    expect_ack('0, "pop_cycle_no_push");
    next_cycle();
    #1;
    expect_ack(5'b01000, "granted_after_pop");
    next_cycle();
    ch_valid = '0;
    check_status(1'b1, '0);

    // FLUSH with three entries queued and channel 1 requesting
    repeat (5) check_tag();
    check_status(1'b1, '0);
    next_cycle();
    wbs_stb = 1'b1; wbs_cyc = 1'b1; wbs_we = 1'b1; wbs_adr = ADR_CTRL; wbs_dat_w = 32'h8000_001F;
    ch_ts[1*TS_W +: TS_W] = 32'h0000_0ABC;
    ch_valid = 5'b00010;
    #1;
    expect_ack('0, "flush_cycle_no_grant");
    next_cycle();
    wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0;
    #1;
    check("flush_wb_ack", 32'(wbs_ack), 32'd1);
    sb.delete();
    expect_ack(5'b00010, "grant_after_flush");
    next_cycle();
    ch_valid = '0;
    check_status(1'b0, '0);
    check_ts();
    check_tag();

    // Reset while a bus cycle is in flight and four entries are queued
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ch_valid = 5'(1 << i);
      #1;
      expect_ack(ch_valid, "refill");
    end
    next_cycle();
    ch_valid = '0;
    wbs_stb = 1'b1; wbs_cyc = 1'b1; wbs_we = 1'b0; wbs_adr = ADR_STATUS;
    rst = 1'b1;
    next_cycle();
    #1;
    check("rst_inflight_no_ack_0", 32'(wbs_ack), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_inflight_no_ack_1", 32'(wbs_ack), 32'd0);
    next_cycle();
    wbs_stb = 1'b0; wbs_cyc = 1'b0;
    #1;
    check("rst_inflight_no_ack_2", 32'(wbs_ack), 32'd0);
    sb.delete();
    check_status(1'b0, '0);
    wb_read(ADR_CTRL, rdat);
    check("ctrl_cleared_by_rst", rdat, 32'd0);
    next_cycle();
    ch_valid = '1;
    #1;
    expect_ack('0, "no_ack_while_disabled");
    wb_write(ADR_CTRL, 32'h0000_0001);
    expect_ack(5'b00001, "ack_after_ctrl_rewrite");
    next_cycle();
    ch_valid = '0;
    check_status(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
